// File: rtl/phy_mgmt_hub_if.sv
// phy_mgmt_hub_if: upstream Wishbone bus with a 10-bit {phy, reg} address.
interface phy_mgmt_hub_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic        ack;
    logic        err;
    modport master (output cyc, stb, we, addr, data_write, input data_read, ack, err);
    modport slave  (input cyc, stb, we, addr, data_write, output data_read, ack, err);
endinterface

// File: rtl/phy_mgmt_hub.sv
// phy_mgmt_hub: routes {phy, reg} Wishbone accesses to per-PHY register ports and owns a link-change irq block.
// Optional PHY_HUB_TIMEOUT_EN bounds how long a port may stall before the access ends in err.
module phy_mgmt_hub #(
    parameter int PORTS     = 4,
    parameter int BASE_ADDR = 0,
    parameter int HUB_ADDR  = 31,
    parameter int TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    phy_mgmt_hub_if.slave         wb,
    output logic [PORTS-1:0]      port_cyc_o,
    output logic [PORTS-1:0]      port_stb_o,
    output logic                  port_we_o,
    output logic [4:0]            port_addr_o,
    output logic [15:0]           port_data_write_o,
    input  logic [16*PORTS-1:0]   port_data_read_i,
    input  logic [PORTS-1:0]      port_ack_i,
    input  logic [PORTS-1:0]      port_err_i,
    input  logic [PORTS-1:0]      link_status_i,
    output logic                  irq_o
);
    localparam int SW = PORTS > 1 ? $clog2(PORTS) : 1;
    typedef enum logic [1:0] {IDLE, PORT, DONE} state_t;
    state_t           state_q, state_d;
    logic [PORTS-1:0] stb_q, stb_d, mask_q, mask_d, latch_q, latch_d, prev_q;
    logic [SW-1:0]    sel_q, sel_d;
    logic             we_q, we_d, ack_q, ack_d, err_q, err_d, irq_q;
    logic [4:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d, rdata_q, rdata_d, hub_rd;
    logic [4:0]       phy, rg;
    logic [5:0]       off;
    logic             is_hub, is_port, hub_wr, hit, tmo;
    assign phy = wb.addr[9:5];
    assign rg  = wb.addr[4:0];
    // A phy below BASE_ADDR wraps to >= 33, so one compare covers both bounds.
    assign off     = {1'b0, phy} - 6'(BASE_ADDR);
    assign is_hub  = phy == 5'(HUB_ADDR);
    assign is_port = !is_hub && off < 6'(PORTS);
    assign hub_wr  = state_q == IDLE && wb.cyc && wb.stb && is_hub && wb.we;
    assign hub_rd  = rg == 5'd0 ? 16'(link_status_i) :
                     rg == 5'd1 ? 16'(latch_q) :
                     rg == 5'd2 ? 16'(mask_q) : 16'h0000;
    assign hit     = port_ack_i[sel_q] || port_err_i[sel_q];
    // A new change is ORed in after the W1C so a same-cycle set survives the clear.
    assign latch_d = (latch_q & ~((hub_wr && rg == 5'd1) ? wb.data_write[PORTS-1:0] : '0))
                   | (link_status_i ^ prev_q);
    assign mask_d  = (hub_wr && rg == 5'd2) ? wb.data_write[PORTS-1:0] : mask_q;
`ifdef PHY_HUB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d = state_q == PORT ? cnt_q + 8'd1 : 8'd0;
    assign tmo   = cnt_q + 8'd1 == 8'(TIMEOUT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (wb.cyc && wb.stb) begin
                state_d = is_port ? PORT : DONE;
                ack_d   = !is_port;
                rdata_d = is_hub ? hub_rd : is_port ? rdata_q : 16'hFFFF;
                if (is_port) begin
                    stb_d   = PORTS'(1) << off[SW-1:0];
                    sel_d   = off[SW-1:0];
                    we_d    = wb.we;
                    addr_d  = rg;
                    wdata_d = wb.data_write;
                end
            end
            PORT: if (hit || !wb.cyc || tmo) begin
                state_d = (!hit && !wb.cyc) ? IDLE : DONE;
                stb_d   = '0;
                rdata_d = hit ? port_data_read_i[16*sel_q +: 16] : rdata_q;
                ack_d   = hit && port_ack_i[sel_q];
                err_d   = hit ? !port_ack_i[sel_q] : wb.cyc;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stb_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            latch_q <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            latch_q <= latch_d;
            prev_q  <= link_status_i;
            irq_q   <= |(latch_q & mask_q);
        end
    end
    assign wb.data_read      = rdata_q;
    assign wb.ack            = ack_q;
    assign wb.err            = err_q;
    assign port_cyc_o        = stb_q;
    assign port_stb_o        = stb_q;
    assign port_we_o         = we_q;
    assign port_addr_o       = addr_q;
    assign port_data_write_o = wdata_q;
    assign irq_o             = irq_q;
endmodule

// File: tb/tb_phy_mgmt_hub.sv
// tb_phy_mgmt_hub: randomized scoreboard bench; a high-level register model predicts every termination.
module tb_phy_mgmt_hub;
    localparam int P = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    phy_mgmt_hub_if wb();
    logic [P-1:0]    port_cyc, port_stb, port_ack, port_err, link;
    logic            port_we, irq;
    logic [4:0]      port_addr;
    logic [15:0]     port_wd;
    logic [16*P-1:0] port_rd;
    phy_mgmt_hub #(.PORTS(P), .BASE_ADDR(0), .HUB_ADDR(31), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb),
        .port_cyc_o(port_cyc), .port_stb_o(port_stb), .port_we_o(port_we),
        .port_addr_o(port_addr), .port_data_write_o(port_wd),
        .port_data_read_i(port_rd), .port_ack_i(port_ack), .port_err_i(port_err),
        .link_status_i(link), .irq_o(irq)
    );
    typedef struct {logic err; logic [15:0] data;} exp_t;
    exp_t q[$];
    exp_t me;
    int checks = 0, passes = 0;
    logic [P-1:0] m_latch, m_mask, m_link;
    int r_mode = 0;  // 0: no strobe expected, 1: respond, 2: stay silent
    int r_sel, r_lat;
    logic r_we, r_err;
    logic [4:0] r_addr;
    logic [15:0] r_wd, r_data;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    endtask

    always @(negedge clk) if (rst_n && (wb.ack || wb.err)) begin
        if (q.size() == 0) chk("unexpected_term", {30'd0, wb.ack, wb.err}, 32'd0);
        else begin
            me = q.pop_front();
            chk("term_kind", {30'd0, wb.ack, wb.err}, {30'd0, !me.err, me.err});
            if (!me.err) chk("rdata", {16'd0, wb.data_read}, {16'd0, me.data});
        end
    end

    initial begin
        port_ack = '0; port_err = '0; port_rd = '0;
        forever begin
            @(negedge clk);
            if (port_stb != '0 && r_mode == 0) chk("stray_stb", {28'd0, port_stb}, 32'd0);
            else if (port_stb != '0 && r_mode == 1) begin
                chk("port_stb", {28'd0, port_stb}, 32'(P'(1) << r_sel));
                chk("port_cyc", {28'd0, port_cyc}, 32'(P'(1) << r_sel));
                chk("port_we", {31'd0, port_we}, {31'd0, r_we});
                chk("port_addr", {27'd0, port_addr}, {27'd0, r_addr});
                chk("port_wd", {16'd0, port_wd}, {16'd0, r_wd});
                repeat (r_lat - 1) begin
                    port_ack[(r_sel + 1) % P] = 1'b1;
                    port_rd = {$urandom, $urandom};
                    @(negedge clk);
                    port_ack = '0;
                end
                port_rd = {$urandom, $urandom};
                port_rd[16*r_sel +: 16] = r_data;
                if (r_err) port_err[r_sel] = 1'b1;
                else port_ack[r_sel] = 1'b1;
                r_mode = 0;
                @(negedge clk);
                port_ack = '0; port_err = '0;
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.addr = {phy, rg}; wb.data_write = wd;
    endtask

    task automatic release_bus();
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic req(input logic we, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                       input logic [P-1:0] nl, input int lat, input logic perr, input logic [15:0] pd);
        int n;
        logic [P-1:0] chg;
        exp_t e;
        chg = m_link ^ nl;
        e.err = 1'b0;
        if (phy == 5'd31) begin
            e.data = rg == 0 ? 16'(nl) : rg == 1 ? 16'(m_latch) : rg == 2 ? 16'(m_mask) : 16'h0000;
            if (we && rg == 1) m_latch = m_latch & ~wd[P-1:0];
            if (we && rg == 2) m_mask = wd[P-1:0];
        end else if (int'(phy) < P) begin
            r_sel = int'(phy); r_we = we; r_addr = rg; r_wd = wd; r_data = pd; r_lat = lat; r_err = perr;
            r_mode = 1;
            e.err = perr; e.data = pd;
        end else e.data = 16'hFFFF;
        q.push_back(e);
        m_latch = m_latch | chg;
        m_link = nl;
        link = nl;
        drive(we, phy, rg, wd);
        n = 0;
        do begin @(negedge clk); n++; end while (!(wb.ack || wb.err) && n < 40);
        chk("term_within_bound", {31'd0, n < 40}, 32'd1);
        release_bus();
        @(negedge clk);
        chk("irq", {31'd0, irq}, {31'd0, |(m_latch & m_mask)});
    endtask

    task automatic rnd_req();
        int op;
        logic [4:0] phy, rg;
        logic [P-1:0] nl;
        op = $urandom_range(0, 2);
        phy = op == 0 ? 5'd31 : op == 1 ? 5'($urandom_range(0, P - 1)) : 5'($urandom_range(P, 30));
        rg = op == 0 ? 5'($urandom_range(0, 4)) : 5'($urandom);
        nl = $urandom_range(0, 9) < 3 ? P'($urandom) : m_link;
        req(1'($urandom), phy, rg, 16'($urandom), nl, $urandom_range(1, 6), $urandom_range(0, 4) == 0, 16'($urandom));
    endtask

    initial begin
        int n;
        release_bus();
        wb.addr = '0; wb.data_write = '0;
        link = 4'b0001; m_link = 4'b0001;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, wb.ack}, 32'd0);
        chk("rst_err", {31'd0, wb.err}, 32'd0);
        chk("rst_rdata", {16'd0, wb.data_read}, 32'd0);
        chk("rst_port_cyc", {28'd0, port_cyc}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        m_latch = m_link; m_mask = '0;
        @(negedge clk);
        req(0, 31, 1, 0, 4'b0001, 1, 0, 0);
        req(1, 31, 1, 16'hFFFF, 4'b0001, 1, 0, 0);
        req(0, 2, 1, 0, 4'b0001, 3, 0, 16'h7849);
        req(1, 0, 0, 16'h8000, 4'b0001, 2, 0, 16'h1234);
        req(0, 20, 3, 0, 4'b0001, 1, 0, 0);
        req(1, 31, 2, 16'h0002, 4'b0001, 1, 0, 0);
        req(0, 31, 0, 0, 4'b0011, 1, 0, 0);
        req(0, 31, 1, 0, 4'b0011, 1, 0, 0);
        req(1, 31, 1, 16'h0002, 4'b0001, 1, 0, 0);
        req(0, 31, 1, 0, 4'b0001, 1, 0, 0);
        req(1, 31, 1, 16'h0002, 4'b0001, 1, 0, 0);
        req(0, 31, 1, 0, 4'b0001, 1, 0, 0);
        req(0, 1, 7, 0, 4'b0001, 2, 1, 16'hBEEF);
        // stalled port: timeout err when enabled, otherwise a master abort
        r_mode = 2;
`ifdef PHY_HUB_TIMEOUT_EN
        q.push_back('{err: 1'b1, data: 16'h0000});
        drive(0, 1, 4, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(wb.ack || wb.err) && n < 40);
        chk("tmo_latency", n, 16);
        release_bus();
        @(negedge clk);
        chk("tmo_stb_drop", {28'd0, port_stb}, 32'd0);
`else
        drive(0, 1, 4, 0);
        repeat (6) @(negedge clk);
        chk("hang_stb", {28'd0, port_stb}, 32'h2);
        release_bus();
        @(negedge clk);
        chk("abort_stb_drop", {28'd0, port_cyc}, 32'd0);
`endif
        r_mode = 0;
        @(negedge clk);
        req(0, 31, 2, 0, m_link, 1, 0, 0);
        r_mode = 2;
        drive(1, 3, 9, 16'h5555);
        repeat (3) @(negedge clk);
        chk("pre_rst_stb", {28'd0, port_stb}, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cyc", {28'd0, port_cyc}, 32'd0);
        chk("rst_no_ack", {30'd0, wb.ack, wb.err}, 32'd0);
        release_bus();
        @(negedge clk);
        rst_n = 1'b1;
        r_mode = 0;
        m_mask = '0; m_latch = m_link;
        req(0, 3, 9, 0, m_link, 2, 0, 16'hA5A5);
        req(0, 31, 2, 0, m_link, 1, 0, 0);
        req(0, 31, 1, 0, m_link, 1, 0, 0);
        for (int i = 0; i < 150; i++) rnd_req();
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
